// File: rtl/ads1115_scan_ctrl.sv
// +-----------------------------------------------------------------------------+
// | ads1115_scan_ctrl : round-robin, pipelined ADS1115 channel scan scheduler     |
// | Revision 1.0                                                                  |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ads1115_scan_ctrl #(
  parameter logic [6:0]  DEV_ADDR   = 7'h48,
  parameter logic [7:0]  CFG_LSB    = 8'h83,
  parameter int unsigned CONV_WAIT  = 400000,
  parameter int unsigned PERIOD_CYC = 2000000,
  parameter int unsigned TIMEOUT    = 4000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  ch_mask,
  input  logic [2:0]  pga,
  input  logic        err_clr,
  input  logic        i2c_busy,
  input  logic [7:0]  i2c_a0m,
  input  logic [7:0]  i2c_a0l,
  output logic [7:0]  cam,
  output logic [7:0]  cal,
  output logic [7:0]  ad1,
  output logic [7:0]  ad2,
  output logic [7:0]  ad3,
  output logic [7:0]  writei2c,
  output logic [7:0]  stopi2c,
  output logic        result_valid,
  output logic [1:0]  result_ch,
  output logic [15:0] result_data,
  output logic        scan_done,
  input  logic [1:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(PERIOD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_CAPTURE = 3'd2,
    S_WAIT    = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic          busy_s1, busy_s2, busy_s3;
  logic          fall;
  logic [3:0]    scan_mask;
  logic [1:0]    ch, prev_ch, deliv_ch;
  logic          prev_last, deliv_last;
  logic          prime, drain_pend, cap_cnt;
  logic [TW-1:0] to_cnt;
  logic [WW-1:0] wt_cnt;
  logic [15:0]   store [4];
  logic          above_found, low_found, start, timeout;
  logic [1:0]    above_ch, low_ch;

  function automatic logic [7:0] cfg_msb(input logic [1:0] c, input logic [2:0] g);
    return {2'b11, c, g, 1'b1};
  endfunction

  assign cal = CFG_LSB;
  assign ad1 = {1'b0, DEV_ADDR};
  assign ad2 = 8'h01;
  assign ad3 = 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      busy_s3 <= 1'b0;
    end else begin
      busy_s1 <= i2c_busy;
      busy_s2 <= busy_s1;
      busy_s3 <= busy_s2;
    end
  end

  assign fall = busy_s3 & ~busy_s2;

  // Next set bit above ch in the live scan mask; lowest set bit of the incoming mask.
  always_comb begin
    above_found = 1'b0;
    above_ch    = ch;
    low_found   = 1'b0;
    low_ch      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (scan_mask[i] && (3'(i) > {1'b0, ch})) begin
        above_found = 1'b1;
        above_ch    = 2'(i);
      end
      if (ch_mask[i]) begin
        low_found = 1'b1;
        low_ch    = 2'(i);
      end
    end
  end

  assign start   = enable && (ch_mask != 4'd0);
  assign timeout = (state == S_LAUNCH) && !fall && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    writei2c = 8'h00;
    stopi2c  = 8'h00;
    case (state)
      S_IDLE: begin
        stopi2c = 8'h01;
        if (start) state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        writei2c = 8'h01;
        if (fall)         state_n = S_CAPTURE;
        else if (timeout) state_n = S_IDLE;
      end
      S_CAPTURE: begin
        if (cap_cnt) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wt_cnt == '0) state_n = (enable && !drain_pend) ? S_LAUNCH : S_DRAIN;
      end
      S_DRAIN: begin
        stopi2c = 8'h01;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cam          <= cfg_msb(2'd0, 3'd0);
      scan_mask    <= 4'd0;
      ch           <= 2'd0;
      prev_ch      <= 2'd0;
      deliv_ch     <= 2'd0;
      prev_last    <= 1'b0;
      deliv_last   <= 1'b0;
      prime        <= 1'b0;
      drain_pend   <= 1'b0;
      cap_cnt      <= 1'b0;
      to_cnt       <= '0;
      wt_cnt       <= '0;
      result_valid <= 1'b0;
      result_ch    <= 2'd0;
      result_data  <= 16'h0000;
      scan_done    <= 1'b0;
      rd_data      <= 16'h0000;
      err          <= 1'b0;
      for (int i = 0; i < 4; i++) store[i] <= 16'h0000;
    end else begin
      result_valid <= 1'b0;
      scan_done    <= 1'b0;
      rd_data      <= store[rd_sel];

      if (err_clr)      err <= 1'b0;
      else if (timeout) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            scan_mask  <= ch_mask;
            ch         <= low_ch;
            cam        <= cfg_msb(low_ch, pga);
            prime      <= 1'b0;
            prev_last  <= 1'b0;
            drain_pend <= 1'b0;
            to_cnt     <= '0;
          end
        end
        S_LAUNCH: begin
          to_cnt <= to_cnt + 1'b1;
          if (fall) begin
            // This transaction read the conversion started by the previous one.
            deliv_ch   <= prev_ch;
            deliv_last <= prev_last;
            prev_ch    <= ch;
            prev_last  <= !above_found;
            cap_cnt    <= 1'b0;
            if (above_found) begin
              ch  <= above_ch;
              cam <= cfg_msb(above_ch, pga);
            end else begin
              scan_mask <= ch_mask;
              if (low_found) begin
                ch  <= low_ch;
                cam <= cfg_msb(low_ch, pga);
              end else begin
                drain_pend <= 1'b1;
              end
            end
          end
        end
        S_CAPTURE: begin
          cap_cnt <= 1'b1;
          if (cap_cnt) begin
            if (prime) begin
              result_valid    <= 1'b1;
              result_ch       <= deliv_ch;
              result_data     <= {i2c_a0m, i2c_a0l};
              scan_done       <= deliv_last;
              store[deliv_ch] <= {i2c_a0m, i2c_a0l};
            end
            prime <= 1'b1;
            // Three cycles of the gap are already spent in LAUNCH->CAPTURE->WAIT.
            wt_cnt <= (prime && deliv_last) ? WW'(PERIOD_CYC - 3) : WW'(CONV_WAIT - 3);
          end
        end
        S_WAIT: begin
          if (wt_cnt != '0) wt_cnt <= wt_cnt - 1'b1;
          else              to_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
